// File: rtl/operand_fwd_stage_pkg.sv
// Shared widths, zero-register constant and FIFO entry layout for operand_fwd_stage.
// Forwarding fields exist only when OPFWD_FORWARD_EN is defined.
package operand_fwd_stage_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_REG_W  = 3;

    localparam logic [DEF_REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rf;
`ifdef OPFWD_FORWARD_EN
        logic [DEF_DATA_W-1:0] fwd;
        logic [DEF_REG_W-1:0]  src;
        logic                  hit;
`endif
    } opfwd_entry_t;

endpackage

// File: rtl/operand_fwd_stage_match.sv
// opfwd_match: flags a write-back that targets a given source register (never r0).
// Only built when OPFWD_FORWARD_EN is defined.
`ifdef OPFWD_FORWARD_EN
module opfwd_match
    import operand_fwd_stage_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    input  logic [REG_W-1:0] src_reg,
    output logic             hit
);

    assign hit = wb_valid && (wb_reg == src_reg) && (wb_reg != REG_W'(ZERO_REG));

endmodule
`endif

// File: rtl/operand_fwd_stage.sv
// Two-entry operand FIFO with write-back snooping; forwarding is compiled in by OPFWD_FORWARD_EN.
// Entry layout comes from operand_fwd_stage_pkg, so DATA_W/REG_W must stay at the package widths.
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_src_reg,
    input  logic [DATA_W-1:0] in_rf_data,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data1,
    output logic [DATA_W:0]   out_data2,
    output logic              out_select
);

    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;
    opfwd_entry_t entries      [2];
    opfwd_entry_t entries_next [2];
    opfwd_entry_t new_entry;
    opfwd_entry_t head;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef OPFWD_FORWARD_EN
    logic       push_hit;
    logic [1:0] snoop_hit;

    opfwd_match #(.REG_W(REG_W)) u_push_match (
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .src_reg  (in_src_reg),
        .hit      (push_hit)
    );

    for (genvar g = 0; g < 2; g++) begin : g_snoop
        opfwd_match #(.REG_W(REG_W)) u_entry_match (
            .wb_valid (wb_valid),
            .wb_reg   (wb_reg),
            .src_reg  (entries[g].src),
            .hit      (snoop_hit[g])
        );
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{in_src_reg, wb_valid, wb_reg, wb_data};
`endif

    always_comb begin
        new_entry    = '0;
        new_entry.rf = in_rf_data;
`ifdef OPFWD_FORWARD_EN
        new_entry.src = in_src_reg;
        new_entry.hit = push_hit;
        new_entry.fwd = push_hit ? wb_data : '0;
`endif
    end

    // Snoop every slot (empty ones too, they are overwritten on push), then land the push.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            entries_next[i] = entries[i];
`ifdef OPFWD_FORWARD_EN
            if (snoop_hit[i]) begin
                entries_next[i].hit = 1'b1;
                entries_next[i].fwd = wb_data;
            end
`endif
        end
        if (push) begin
            entries_next[wr_ptr] = new_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                entries[i] <= '0;
            end
        end else begin
            count  <= count + {1'b0, push} - {1'b0, pop};
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            for (int i = 0; i < 2; i++) begin
                entries[i] <= entries_next[i];
            end
        end
    end

    assign head      = entries[rd_ptr];
    assign out_data1 = {out_valid, out_valid ? head.rf : {DATA_W{1'b0}}};

`ifdef OPFWD_FORWARD_EN
    assign out_data2  = {out_valid, out_valid ? head.fwd : {DATA_W{1'b0}}};
    assign out_select = out_valid & head.hit;
`else
    assign out_data2  = {out_valid, {DATA_W{1'b0}}};
    assign out_select = 1'b0;
`endif

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage with a queue-based reference model.
// Honours OPFWD_FORWARD_EN the same way as the design.
module tb_operand_fwd_stage;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_src_reg;
    logic [7:0] in_rf_data;
    logic       wb_valid;
    logic [2:0] wb_reg;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data1;
    logic [8:0] out_data2;
    logic       out_select;

    int checkCount = 0;
    int passCount  = 0;

`ifdef OPFWD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    operand_fwd_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_src_reg (in_src_reg),
        .in_rf_data (in_rf_data),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_select (out_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rf;
        logic [2:0] src;
        bit         hit;
        logic [7:0] fwd;
    } model_entry_t;

    model_entry_t q[$];

    // Reference model: a queue of at most two operands, snooped by every write-back.
    always @(posedge clk or negedge reset_n) begin : model
        bit           doPush;
        bit           doPop;
        model_entry_t n;
        if (!reset_n) begin
            q.delete();
        end else begin
            doPush = in_valid && (q.size() < 2);
            doPop  = out_ready && (q.size() != 0);
            if (FWD && wb_valid && wb_reg != 3'd0) begin
                foreach (q[i]) begin
                    if (q[i].src == wb_reg) begin
                        q[i].hit = 1'b1;
                        q[i].fwd = wb_data;
                    end
                end
            end
            if (doPop) void'(q.pop_front());
            if (doPush) begin
                n.rf  = in_rf_data;
                n.src = in_src_reg;
                n.hit = FWD && wb_valid && (wb_reg == in_src_reg) && (in_src_reg != 3'd0);
                n.fwd = n.hit ? wb_data : 8'h00;
                q.push_back(n);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : compare
        bit         v;
        logic [8:0] e1;
        logic [8:0] e2;
        bit         es;
        v  = (q.size() != 0);
        e1 = v ? {1'b1, q[0].rf} : 9'h000;
        e2 = v ? {1'b1, q[0].fwd} : 9'h000;
        es = v && q[0].hit;
        checkOutput("model_in_ready",  32'(in_ready),   32'(q.size() < 2));
        checkOutput("model_out_valid", 32'(out_valid),  32'(v));
        checkOutput("model_out_data1", 32'(out_data1),  32'(e1));
        checkOutput("model_out_data2", 32'(out_data2),  32'(e2));
        checkOutput("model_out_select", 32'(out_select), 32'(es));
    end

    task automatic applyStimulus(input logic v, input logic [2:0] src, input logic [7:0] rf,
                                 input logic wv, input logic [2:0] wr, input logic [7:0] wd,
                                 input logic ordy);
        in_valid   = v;
        in_src_reg = src;
        in_rf_data = rf;
        wb_valid   = wv;
        wb_reg     = wr;
        wb_data    = wd;
        out_ready  = ordy;
        @(posedge clk);
        #2;
    endtask

    task automatic popOne();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_src_reg = '0; in_rf_data = '0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b0;
        #3;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data1", 32'(out_data1), 32'h000);
        checkOutput("reset_out_data2", 32'(out_data2), 32'h000);
        checkOutput("reset_out_select", 32'(out_select), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Basic push with no write-back
        applyStimulus(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 8'h00, 1'b0);
        checkOutput("req024_out_valid", 32'(out_valid), 32'd1);
        checkOutput("req024_out_data1", 32'(out_data1), 32'h111);
        checkOutput("req024_out_select", 32'(out_select), 32'd0);
        popOne();

        // Same-cycle forward on push
        applyStimulus(1'b1, 3'd3, 8'h22, 1'b1, 3'd3, 8'hA5, 1'b0);
        checkOutput("req025_out_select", 32'(out_select), 32'(FWD));
        checkOutput("req025_out_data2", 32'(out_data2), FWD ? 32'h1A5 : 32'h100);
        checkOutput("req025_out_data1", 32'(out_data1), 32'h122);
        popOne();

        // Full FIFO back-pressure
        applyStimulus(1'b1, 3'd1, 8'h31, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 3'd4, 8'h32, 1'b0, 3'd0, 8'h00, 1'b0);
        checkOutput("req026_full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 3'd6, 8'h33, 1'b0, 3'd0, 8'h00, 1'b0);
        checkOutput("req026_third_ignored", 32'(out_data1), 32'h131);
        popOne();
        checkOutput("req026_pop_in_ready", 32'(in_ready), 32'd1);
        checkOutput("req026_next_head", 32'(out_data1), 32'h132);
        popOne();
        checkOutput("req026_drained", 32'(out_valid), 32'd0);
        popOne();

        // Youngest write-back wins on a buffered entry
        applyStimulus(1'b1, 3'd5, 8'h44, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h3C, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h7E, 1'b0);
        checkOutput("req027_out_data2", 32'(out_data2), FWD ? 32'h17E : 32'h100);
        checkOutput("req027_out_select", 32'(out_select), 32'(FWD));
        popOne();

        // Register 0 never forwards
        applyStimulus(1'b1, 3'd0, 8'h55, 1'b1, 3'd0, 8'hFF, 1'b0);
        checkOutput("req028_out_select", 32'(out_select), 32'd0);
        checkOutput("req028_out_data2", 32'(out_data2), 32'h100);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h12, 1'b0);
        checkOutput("req028_snoop_r0", 32'(out_select), 32'd0);
        popOne();

        // Simultaneous push and pop at count 1
        applyStimulus(1'b1, 3'd1, 8'h61, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 3'd2, 8'h62, 1'b1, 3'd1, 8'h9A, 1'b1);
        checkOutput("pushpop_out_data1", 32'(out_data1), 32'h162);
        checkOutput("pushpop_in_ready", 32'(in_ready), 32'd1);
        checkOutput("pushpop_out_select", 32'(out_select), 32'd0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h5B, 1'b1);
        checkOutput("pushpop_empty", 32'(out_valid), 32'd0);

        // Pending entry and new entry both hit by one write-back
        applyStimulus(1'b1, 3'd6, 8'h81, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 3'd6, 8'h82, 1'b1, 3'd6, 8'hC3, 1'b0);
        checkOutput("dualhit_head_data2", 32'(out_data2), FWD ? 32'h1C3 : 32'h100);
        popOne();
        checkOutput("dualhit_tail_data2", 32'(out_data2), FWD ? 32'h1C3 : 32'h100);
        popOne();

        // Reset with a full FIFO
        applyStimulus(1'b1, 3'd2, 8'h71, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 3'd3, 8'h72, 1'b0, 3'd0, 8'h00, 1'b0);
        checkOutput("req029_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("req029_out_valid", 32'(out_valid), 32'd0);
        checkOutput("req029_in_ready", 32'(in_ready), 32'd1);
        checkOutput("req029_out_data1", 32'(out_data1), 32'h000);
        @(posedge clk);
        #2 reset_n = 1'b1;
        applyStimulus(1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 8'h00, 1'b0);
        checkOutput("req029_repush_valid", 32'(out_valid), 32'd1);
        checkOutput("req029_repush_data1", 32'(out_data1), 32'h177);
        popOne();
        popOne();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
